uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Parametrised UART receiver: the next-generation successor to the fixed 9600-bps, 8N1 receive path used by the board-level UART labs. It synchronises the asynchronous `uart_rx` line, oversamples each bit, and delivers frames through a valid/ready holding register. It also reports framing, parity and overrun errors. It sits between the board `uart_rx` pin and the application logic (command parser / echo logic) and runs entirely in the system clock domain.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bps
- `DATA_BITS`, 8, payload bits per frame; legal range 5–9
- `OVERSAMPLE`, 16, sample ticks per bit; even, ≥ 8
- `STOP_BITS`, 1, stop bits checked; 1 or 2
- `PARITY_ODD`, 0, parity sense: 0 = even, 1 = odd; used only with `UART_RX_PARITY_EN`

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `uart_rx`  in  1  serial line; idle high; asynchronous to `clk`
- `rx_data`  out  DATA_BITS  received payload, LSB first on the line; reset 0
- `rx_valid`  out  1  holding register full; reset 0
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; reset 0
- `parity_err`  out  1  one-cycle pulse: parity mismatch; reset 0; tied 0 without the macro
- `overrun_err`  out  1  one-cycle pulse: frame completed while the holding register was full; reset 0
- `busy`  out  1  FSM not in IDLE; reset 0

## Operation
- Input sync: 2-FF synchroniser on `uart_rx`, both stages reset to 1.
- Tick generator: DIV = round(CLK_HZ / (BAUD·OVERSAMPLE)), minimum 1. A counter 0..DIV-1 emits a one-cycle `tick` at wrap. The counter is free-running.
- Sample counter `scnt` (0..OVERSAMPLE-1) advances on `tick`. Majority vote uses 3 samples at `scnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit decision is made at OVERSAMPLE/2+1.
- FSM states:
  - IDLE → START on a falling edge of the synchronised line; `scnt` is cleared.
  - START: if the vote is 1, this is a false start → IDLE; otherwise continue to the end of the bit → DATA.
  - DATA: shift in DATA_BITS bits, LSB first. Bit index `bcnt` counts DATA_BITS-1 → 0. Then go to PARITY (macro defined) or STOP.
  - PARITY: check the bit at mid-sample, then → STOP.
  - STOP: check the vote of each stop bit. After the mid-sample of the last stop bit → IDLE. The FSM does not wait for the end of the bit, so back-to-back frames are accepted.
- Completion, evaluated at the last stop-bit decision:
  - Any stop vote = 0: pulse `frame_err` and discard the frame.
  - Parity bad: pulse `parity_err` and discard the frame.
  - Otherwise, if `rx_valid` = 0 or `rx_ready` = 1 in that cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: pulse `overrun_err`, drop the new byte, and keep the old `rx_data`.
- `rx_valid` clears on handshake. A simultaneous handshake and load keeps it set with the new data.
- `reset_n` low at any time, including mid-frame: FSM → IDLE, all counters → 0, all outputs → reset values. No partial frame is delivered.

## Timing
- Latency from the `uart_rx` falling edge to `rx_valid` rising: 2 sync cycles + (1 + DATA_BITS + P + STOP_BITS − 1) bit times + (OVERSAMPLE/2+2) ticks, ± 1 tick of start-edge jitter. P = 1 with the macro, else 0.
- Error pulses are exactly 1 clk wide and occur in the same cycle a valid load would have occurred.
- `rx_data` is stable while `rx_valid` = 1.
- Baud error tolerance: ≤ ±3 % total.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is compiled in. One parity bit is expected after the data bits; its sense is set by `PARITY_ODD`; `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: there is no PARITY state, frames are DATA → STOP, and `parity_err` is a constant 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - constant function `uart_div(clk_hz, baud, os)`
  - shared constants, reused by a future transmitter
- Sub-module `uart_baud_tick` (parameters CLK_HZ, BAUD, OVERSAMPLE; outputs `tick`) holds the divisor counter.
- The FSM, sampling, shift register and holding register live in `uart_rx_core`.

## Test plan
All scenarios use defaults (CLK_HZ 100 MHz, 9600 bps, DIV = 651), a 104_167 ns bit period, and a 100 MHz bench clock.
- Send 0x0D as 8N1 with `rx_ready` = 1 → one `rx_valid` pulse with `rx_data` = 0x0D; no error pulses; `busy` falls at the stop-bit mid-sample.
- Drive `uart_rx` low for 3 µs, then high → no `rx_valid`; `busy` returns to 0 within one bit time.
- Send 0x41 with the stop bit driven 0 → `frame_err` pulses once; `rx_valid` stays 0.
- Send 0x55 then 0xAA back to back with `rx_ready` = 0 → `rx_data` = 0x55 held; `overrun_err` pulses at the end of 0xAA; raising `rx_ready` clears `rx_valid`.
- With `UART_RX_PARITY_EN` and even parity, send 0x07 with parity bit 0 → `parity_err` pulses and no `rx_valid`. Then send 0x07 with parity bit 1 → `rx_data` = 0x07.
- Assert `reset_n` = 0 for 2 cycles during data bit 4 of 0x3C, then release → outputs are at reset values, no `rx_valid`, and the next clean 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line constants and the baud divisor function.
package uart_pkg;

    localparam logic        UART_IDLE_LEVEL     = 1'b1;
    localparam int unsigned UART_MIN_DATA_BITS  = 5;
    localparam int unsigned UART_MAX_DATA_BITS  = 9;
    localparam int unsigned UART_MIN_OVERSAMPLE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // round(clk_hz / (baud * os)), never below 1
    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned den;
        int unsigned d;
        den = baud * os;
        if (den == 0) return 1;
        d = (clk_hz + den / 2) / den;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every uart_div() clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            tick  <= w_wrap;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with valid/ready holding register and error pulses.
// Define UART_RX_PARITY_EN to compile in the parity bit check.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned SCNT_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W   = $clog2(DATA_BITS);
    localparam int unsigned SMP_A    = OVERSAMPLE / 2 - 1;
    localparam int unsigned SMP_B    = OVERSAMPLE / 2;
    localparam int unsigned SMP_C    = OVERSAMPLE / 2 + 1;
    localparam int unsigned SMP_LAST = OVERSAMPLE - 1;

    if (DATA_BITS < UART_MIN_DATA_BITS || DATA_BITS > UART_MAX_DATA_BITS) begin : g_chk_data_bits
        $error("uart_rx_core: DATA_BITS out of range");
    end
    if (OVERSAMPLE < UART_MIN_OVERSAMPLE || (OVERSAMPLE % 2) != 0) begin : g_chk_oversample
        $error("uart_rx_core: OVERSAMPLE must be even and >= 8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_rx_core: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_chk_parity
        $error("uart_rx_core: PARITY_ODD must be 0 or 1");
    end

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_line_d;
    logic                 w_tick;
    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [SCNT_W-1:0]    r_scnt;
    logic [BCNT_W-1:0]    r_bcnt;
    logic                 r_stop_idx;
    logic                 r_stop_bad;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;

    logic w_fall;
    logic w_decide;
    logic w_bit_end;
    logic w_vote;
    logic w_start;
    logic w_shift_en;
    logic w_bcnt_dec;
    logic w_stop_adv;
    logic w_complete;
    logic w_frame_bad;
    logic w_par_bad;
    logic w_good;
    logic w_load;

    uart_baud_tick #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (w_tick)
    );

    // Two-stage synchroniser plus one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= UART_IDLE_LEVEL;
            r_sync2  <= UART_IDLE_LEVEL;
            r_line_d <= UART_IDLE_LEVEL;
        end else begin
            r_sync1  <= uart_rx;
            r_sync2  <= r_sync1;
            r_line_d <= r_sync2;
        end
    end

    assign w_fall    = r_line_d & ~r_sync2;
    assign w_decide  = w_tick && (r_scnt == SCNT_W'(SMP_C));
    assign w_bit_end = w_tick && (r_scnt == SCNT_W'(SMP_LAST));
    assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_bcnt_dec  = 1'b0;
        w_stop_adv  = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_start     = 1'b1;
                end
            end
            ST_START: begin
                if (w_decide && w_vote) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_shift_en = w_decide;
                if (w_bit_end) begin
                    if (r_bcnt == '0) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_bcnt_dec = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave at the last stop-bit decision so a following start edge is not missed
                if (w_decide) begin
                    if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_bit_end) begin
                    w_stop_adv = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scnt     <= '0;
            r_bcnt     <= '0;
            r_stop_idx <= 1'b0;
            r_stop_bad <= 1'b0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_shift    <= '0;
        end else begin
            if (w_start) begin
                r_scnt <= '0;
            end else if (w_tick) begin
                r_scnt <= (r_scnt == SCNT_W'(SMP_LAST)) ? '0 : r_scnt + SCNT_W'(1);
            end
            if (w_tick && r_scnt == SCNT_W'(SMP_A)) r_s0 <= r_sync2;
            if (w_tick && r_scnt == SCNT_W'(SMP_B)) r_s1 <= r_sync2;
            if (w_start) begin
                r_bcnt <= BCNT_W'(DATA_BITS - 1);
            end else if (w_bcnt_dec) begin
                r_bcnt <= r_bcnt - BCNT_W'(1);
            end
            if (w_shift_en) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (w_start) begin
                r_stop_idx <= 1'b0;
                r_stop_bad <= 1'b0;
            end else begin
                if (w_stop_adv) r_stop_idx <= 1'b1;
                if (r_state == ST_STOP && w_decide && !w_vote) r_stop_bad <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = 1'(PARITY_ODD);

    logic r_par_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par_bit  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (r_state == ST_PARITY && w_decide) r_par_bit <= w_vote;
            parity_err <= w_complete && !w_frame_bad && w_par_bad;
        end
    end

    assign w_par_bad = r_par_bit != ((^r_shift) ^ PAR_SENSE);
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign w_frame_bad = r_stop_bad | ~w_vote;
    assign w_good      = w_complete && !w_frame_bad && !w_par_bad;
    assign w_load      = w_good && (!rx_valid || rx_ready);

    // Holding register and one-cycle status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (w_load) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            frame_err   <= w_complete && w_frame_bad;
            overrun_err <= w_good && rx_valid && !rx_ready;
            busy        <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core; a faster baud rate keeps frames short (160 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int unsigned CLK_HZ     = 100_000_000;
    localparam int unsigned BAUD       = 625_000;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BIT_NS     = 1600;

    localparam logic [1:0] EV_DATA   = 2'd0;
    localparam logic [1:0] EV_FRAME  = 2'd1;
    localparam logic [1:0] EV_PARITY = 2'd2;
    localparam logic [1:0] EV_OVR    = 2'd3;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 uart_rx = 1'b1;
    logic                 rx_ready = 1'b1;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;
    logic                 busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE),
        .STOP_BITS (1),
        .PARITY_ODD(0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d data=0x%0h, required no event", kind, data);
        end else begin
            e = sb_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            if (kind == EV_DATA) check("rx_data", 32'(data), 32'(e.data));
        end
    endtask

    // Monitor: every handshake or error pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) expect_ev(EV_DATA, rx_data);
            if (frame_err)            expect_ev(EV_FRAME, 8'h00);
            if (parity_err)           expect_ev(EV_PARITY, 8'h00);
            if (overrun_err)          expect_ev(EV_OVR, 8'h00);
        end
    end

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Drives one frame; abort_bit >= 0 resets the DUT halfway through that data bit
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl, input logic par_flip,
                              input bit chk_busy, input int abort_bit);
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            if (i == abort_bit) begin
                #(BIT_NS / 2);
                pulse_reset();
                uart_rx = 1'b1;
                return;
            end
            #(BIT_NS);
        end
        if (PAR_ON) begin
            uart_rx = (^data) ^ par_flip;
            #(BIT_NS);
        end
        uart_rx = stop_lvl;
        #(BIT_NS * 4 / 10);
        if (chk_busy) check("busy_before_stop_mid", 32'(busy), 32'd1);
        #(BIT_NS * 4 / 10);
        if (chk_busy) check("busy_after_stop_mid", 32'(busy), 32'd0);
        #(BIT_NS * 2 / 10);
        uart_rx = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, required finish before 500 us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_overrun_err", 32'(overrun_err), 32'd0);
        reset_n = 1'b1;
        #(2 * BIT_NS);

        // Clean frame, consumer always ready
        push(EV_DATA, 8'h0D);
        send_frame(8'h0D, 1'b1, 1'b0, 1'b1, -1);
        #(2 * BIT_NS);

        // Glitch shorter than half a bit is rejected as a false start
        uart_rx = 1'b0;
        #400;
        uart_rx = 1'b1;
        #(BIT_NS);
        check("busy_after_false_start", 32'(busy), 32'd0);
        #(BIT_NS);

        // Stop bit low
        push(EV_FRAME, 8'h00);
        send_frame(8'h41, 1'b0, 1'b0, 1'b0, -1);
        #(2 * BIT_NS);
        check("rx_valid_after_frame_err", 32'(rx_valid), 32'd0);

        // Back-to-back frames with the consumer stalled
        @(posedge clk);
        #1 rx_ready = 1'b0;
        push(EV_OVR, 8'h00);
        push(EV_DATA, 8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'hAA, 1'b1, 1'b0, 1'b0, -1);
        #(2 * BIT_NS);
        check("held_rx_valid", 32'(rx_valid), 32'd1);
        check("held_rx_data", 32'(rx_data), 32'h55);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rx_valid_after_handshake", 32'(rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        push(EV_PARITY, 8'h00);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
        #(2 * BIT_NS);
        check("rx_valid_after_parity_err", 32'(rx_valid), 32'd0);
        push(EV_DATA, 8'h07);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1);
        #(2 * BIT_NS);
`endif

        // Reset during data bit 4, then a clean frame
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 4);
        #1;
        check("midreset_rx_valid", 32'(rx_valid), 32'd0);
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        check("midreset_overrun_err", 32'(overrun_err), 32'd0);
        #(2 * BIT_NS);
        push(EV_DATA, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
        #(2 * BIT_NS);

        check("scoreboard_pending", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
